// File: rtl/traffic_light_monitor_if.sv
// Bus between the intersection controller/supervisor (master) and the
// traffic_light_monitor checker (slave).
interface traffic_light_monitor_if #(
    parameter int unsigned CYC_W = 16
);
    logic [2:0]       lights_in;
    logic             clear_fault;
    logic             fault;
    logic [2:0]       fault_code;
    logic             phase_ok;
    logic [1:0]       cur_phase;
    logic [CYC_W-1:0] cycle_count;
    logic             safe_flash;

    modport master (
        output lights_in,
        output clear_fault,
        input  fault,
        input  fault_code,
        input  phase_ok,
        input  cur_phase,
        input  cycle_count,
        input  safe_flash
    );

    modport slave (
        input  lights_in,
        input  clear_fault,
        output fault,
        output fault_code,
        output phase_ok,
        output cur_phase,
        output cycle_count,
        output safe_flash
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Independent checker for the RED->GREEN->YELLOW lights bus: legality, order and dwell.
// Optional fault flash request is built only when TLM_FLASH_OVERRIDE_EN is defined.
module traffic_light_monitor #(
    parameter int unsigned PHASE_TICKS = 10000000,
    parameter int unsigned TOL_TICKS   = 16,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned FLASH_TICKS = 5000000
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_light_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        S_SYNC,
        S_TRACK,
        S_FAULT
    } state_t;

    typedef enum logic [2:0] {
        FC_NONE    = 3'd0,
        FC_ILLEGAL = 3'd1,
        FC_BAD_SEQ = 3'd2,
        FC_SHORT   = 3'd3,
        FC_LONG    = 3'd4
    } fcode_t;

    typedef enum logic [1:0] {
        P_NONE   = 2'd0,
        P_RED    = 2'd1,
        P_GREEN  = 2'd2,
        P_YELLOW = 2'd3
    } phase_t;

    localparam logic [2:0] L_RED    = 3'b100;
    localparam logic [2:0] L_GREEN  = 3'b001;
    localparam logic [2:0] L_YELLOW = 3'b010;

    localparam logic [CNT_W-1:0] DWELL_MIN   = CNT_W'(PHASE_TICKS - TOL_TICKS);
    localparam logic [CNT_W-1:0] DWELL_LIMIT = CNT_W'(PHASE_TICKS + TOL_TICKS + 1);

    if (CNT_W < $clog2(PHASE_TICKS + TOL_TICKS + 2)) begin : g_bad_cnt_w
        $error("CNT_W cannot hold PHASE_TICKS+TOL_TICKS+1");
    end
    if (TOL_TICKS >= PHASE_TICKS) begin : g_bad_tol
        $error("TOL_TICKS must be below PHASE_TICKS");
    end
    if (FLASH_TICKS == 0) begin : g_bad_flash
        $error("FLASH_TICKS must be at least 1");
    end

    function automatic phase_t phase_of(input logic [2:0] code);
        case (code)
            L_RED:    return P_RED;
            L_GREEN:  return P_GREEN;
            L_YELLOW: return P_YELLOW;
            default:  return P_NONE;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [2:0]       lights_q;
    logic [CNT_W-1:0] dwell_q, dwell_step, dwell_d;
    logic             seen_q;
    logic             fault_q, fault_d;
    fcode_t           code_q, code_d;
    logic             pok_q, pok_d;
    phase_t           phase_q, phase_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;

    logic   legal_in, changed, seq_ok, clear_dwell;
    logic   violation;
    fcode_t cause;

    assign legal_in = (bus.lights_in == L_RED) || (bus.lights_in == L_GREEN) ||
                      (bus.lights_in == L_YELLOW);
    assign changed  = (bus.lights_in != lights_q);
    assign seq_ok   = ((lights_q == L_RED)    && (bus.lights_in == L_GREEN))  ||
                      ((lights_q == L_GREEN)  && (bus.lights_in == L_YELLOW)) ||
                      ((lights_q == L_YELLOW) && (bus.lights_in == L_RED));

    // Counts samples of the current value; dwell_q before a reload is the measured phase length.
    assign dwell_step = changed ? CNT_W'(1)
                                : ((dwell_q == '1) ? dwell_q : dwell_q + 1'b1);
    assign dwell_d    = clear_dwell ? '0 : dwell_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fault_d     = fault_q;
        code_d      = code_q;
        pok_d       = 1'b0;
        phase_d     = phase_q;
        cyc_d       = cyc_q;
        clear_dwell = 1'b0;
        violation   = 1'b0;
        cause       = FC_NONE;

        case (state_q)
            S_SYNC: begin
                // seen_q keeps the reset value of lights_q from counting as a sample.
                if (!legal_in) begin
                    violation = 1'b1;
                    cause     = FC_ILLEGAL;
                end else if (seen_q && changed) begin
                    state_d = S_TRACK;
                    phase_d = phase_of(bus.lights_in);
                end
            end
            S_TRACK: begin
                if (!legal_in) begin
                    violation = 1'b1;
                    cause     = FC_ILLEGAL;
                end else if (changed && !seq_ok) begin
                    violation = 1'b1;
                    cause     = FC_BAD_SEQ;
                end else if (changed && (dwell_q < DWELL_MIN)) begin
                    violation = 1'b1;
                    cause     = FC_SHORT;
                end else if (!changed && (dwell_step >= DWELL_LIMIT)) begin
                    violation = 1'b1;
                    cause     = FC_LONG;
                end else if (changed) begin
                    pok_d   = 1'b1;
                    phase_d = phase_of(bus.lights_in);
                    if (lights_q == L_YELLOW) begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            S_FAULT: begin
                if (bus.clear_fault) begin
                    state_d     = S_SYNC;
                    fault_d     = 1'b0;
                    code_d      = FC_NONE;
                    cyc_d       = '0;
                    clear_dwell = 1'b1;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        if (violation) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
            code_d  = cause;
            phase_d = P_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lights_q <= '0;
            dwell_q  <= '0;
            seen_q   <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
            pok_q    <= 1'b0;
            phase_q  <= P_NONE;
            cyc_q    <= '0;
        end else begin
            lights_q <= bus.lights_in;
            dwell_q  <= dwell_d;
            seen_q   <= 1'b1;
            fault_q  <= fault_d;
            code_q   <= code_d;
            pok_q    <= pok_d;
            phase_q  <= phase_d;
            cyc_q    <= cyc_d;
        end
    end

    assign bus.fault       = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.phase_ok    = pok_q;
    assign bus.cur_phase   = phase_q;
    assign bus.cycle_count = cyc_q;

`ifdef TLM_FLASH_OVERRIDE_EN
    localparam int unsigned FL_W = $clog2(FLASH_TICKS + 1);

    logic [FL_W-1:0] flash_cnt_q;
    logic            flash_q;

    // Starts high on the fault-entry edge, then holds each level for FLASH_TICKS clocks.
    always_ff @(posedge clk) begin
        if (rst || (state_d != S_FAULT)) begin
            flash_q     <= 1'b0;
            flash_cnt_q <= '0;
        end else if (state_q != S_FAULT) begin
            flash_q     <= 1'b1;
            flash_cnt_q <= FL_W'(1);
        end else if (flash_cnt_q == FL_W'(FLASH_TICKS)) begin
            flash_q     <= ~flash_q;
            flash_cnt_q <= FL_W'(1);
        end else begin
            flash_cnt_q <= flash_cnt_q + 1'b1;
        end
    end

    assign bus.safe_flash = flash_q;
`else
    assign bus.safe_flash = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed vector bench for traffic_light_monitor (PHASE_TICKS=8, TOL_TICKS=1: legal dwell 7..9).
module tb_traffic_light_monitor;

    localparam int unsigned CYC_W = 4;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;

    typedef struct {
        logic        rst_v;
        logic        clr;
        logic [2:0]  lights;
        int unsigned reps;
        logic [10:0] exp;   // {fault, fault_code, phase_ok, cur_phase, cycle_count}
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    traffic_light_monitor_if #(.CYC_W(CYC_W)) bus ();

    traffic_light_monitor #(
        .PHASE_TICKS(8),
        .TOL_TICKS  (1),
        .CNT_W      (8),
        .CYC_W      (CYC_W),
        .FLASH_TICKS(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    vec_t        vecs[$];

    function automatic vec_t mk(input logic r, input logic c, input logic [2:0] l,
                                input int unsigned n, input logic f, input logic [2:0] fc,
                                input logic pk, input logic [1:0] ph, input logic [3:0] cy);
        vec_t v;
        v.rst_v  = r;
        v.clr    = c;
        v.lights = l;
        v.reps   = n;
        v.exp    = {f, fc, pk, ph, cy};
        return v;
    endfunction

    function automatic logic [10:0] obs();
        return {bus.fault, bus.fault_code, bus.phase_ok, bus.cur_phase, bus.cycle_count};
    endfunction

    task automatic step(input logic r, input logic c, input logic [2:0] l);
        rst             = r;
        bus.clear_fault = c;
        bus.lights_in   = l;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got f=%b code=%0d ok=%b phase=%0d cyc=%0d, expected f=%b code=%0d ok=%b phase=%0d cyc=%0d",
                     name, got[10], got[9:7], got[6], got[5:4], got[3:0],
                     exp[10], exp[9:7], exp[6], exp[5:4], exp[3:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    initial begin
        logic [6:0] flash_exp;

        rst             = 1'b1;
        bus.clear_fault = 1'b0;
        bus.lights_in   = R;

        //                rst clr lights   n   f code ok ph cyc
        vecs.push_back(mk(1, 0, R,      2, 0, 0, 0, 0, 0));
        // normal run: GREEN entered from SYNC, then three verified changes
        vecs.push_back(mk(0, 0, R,      3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, G,      8, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, Y,      1, 0, 0, 1, 3, 0));
        vecs.push_back(mk(0, 0, Y,      7, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, R,      1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, R,      7, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, G,      1, 0, 0, 1, 2, 1));
        // illegal multi-hot code, later violations ignored, then clear
        vecs.push_back(mk(0, 0, G,      7, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 0, 3'b110, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, G,      2, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, G,      1, 0, 0, 0, 0, 0));
        // GREEN -> RED is out of order
        vecs.push_back(mk(0, 0, R,      1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, R,      7, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, G,      1, 0, 0, 1, 2, 0));
        vecs.push_back(mk(0, 0, G,      7, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, R,      1, 1, 2, 0, 0, 0));
        // clear wins over a same-edge violation, which is then caught from SYNC
        vecs.push_back(mk(0, 1, 3'b111, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b111, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, R,      1, 0, 0, 0, 0, 0));
        // YELLOW held 6 is short
        vecs.push_back(mk(0, 0, G,      1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, G,      7, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, Y,      1, 0, 0, 1, 3, 0));
        vecs.push_back(mk(0, 0, Y,      5, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, R,      1, 1, 3, 0, 0, 0));
        vecs.push_back(mk(0, 1, R,      1, 0, 0, 0, 0, 0));
        // clear outside FAULT ignored; YELLOW 7 and 9 both accepted
        vecs.push_back(mk(0, 1, G,      1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 1, G,      1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, G,      6, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, Y,      1, 0, 0, 1, 3, 0));
        vecs.push_back(mk(0, 0, Y,      6, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, 0, R,      1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, R,      7, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, G,      1, 0, 0, 1, 2, 1));
        vecs.push_back(mk(0, 0, G,      7, 0, 0, 0, 2, 1));
        vecs.push_back(mk(0, 0, Y,      1, 0, 0, 1, 3, 1));
        vecs.push_back(mk(0, 0, Y,      8, 0, 0, 0, 3, 1));
        vecs.push_back(mk(0, 0, R,      1, 0, 0, 1, 1, 2));
        // RED held: long fault exactly at the 10th sample
        vecs.push_back(mk(0, 0, R,      8, 0, 0, 0, 1, 2));
        vecs.push_back(mk(0, 0, R,      1, 1, 4, 0, 0, 2));
        vecs.push_back(mk(0, 0, R,      2, 1, 4, 0, 0, 2));
        // reset from FAULT, then reset mid-phase in TRACK overriding clear
        vecs.push_back(mk(1, 0, R,      1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, R,      2, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, G,      1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, G,      2, 0, 0, 0, 2, 0));
        vecs.push_back(mk(1, 1, G,      1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, G,      2, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            for (int unsigned k = 0; k < vecs[i].reps; k++) begin
                step(vecs[i].rst_v, vecs[i].clr, vecs[i].lights);
                check_vec($sformatf("vec%0d.%0d", i, k), obs(), vecs[i].exp);
            end
        end

        // cycle_count wraps from all-ones to 0 after 16 verified YELLOW->RED changes
        step(1, 0, R);
        step(0, 0, R);
        for (int j = 0; j < 8; j++) step(0, 0, G);
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 8; j++) step(0, 0, Y);
            step(0, 0, R);
            check_int($sformatf("wrap_cyc%0d", k), int'(bus.cycle_count), (k + 1) % 16);
            for (int j = 0; j < 7; j++) step(0, 0, R);
            for (int j = 0; j < 8; j++) step(0, 0, G);
        end
        check_int("wrap_no_fault", int'(bus.fault), 0);

        // fault flash: illegal code while still in SYNC
`ifdef TLM_FLASH_OVERRIDE_EN
        flash_exp = 7'b1110001;
`else
        flash_exp = 7'b0000000;
`endif
        step(1, 0, R);
        check_int("flash_reset", int'(bus.safe_flash), 0);
        step(0, 0, R);
        step(0, 0, R);
        step(0, 0, 3'b110);
        check_int("flash_fault_code", int'(bus.fault_code), 1);
        for (int j = 0; j < 7; j++) begin
            if (j > 0) step(0, 0, R);
            check_int($sformatf("flash%0d", j), int'(bus.safe_flash), int'(flash_exp[6-j]));
        end
        step(0, 1, R);
        check_int("flash_clear", int'(bus.safe_flash), 0);
        check_int("flash_clear_fault", int'(bus.fault), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
